video_frame_monitor: RTL and testbench

Synthesizable pixel-stream monitor that attaches to the internal VGA timing and draw outputs of the HDMI text controller. It replaces bench-only frame logging with hardware checking. Each frame it produces:
- a CRC-32 signature over all active pixels,
- an active-pixel count,
- a frame counter,
- per-frame and sticky error flags for line length, pixel count, draw-coordinate consistency and line count.

It is parametrised in resolution, total raster size, colour depth and sync polarity. It runs in the pixel domain and is read by a CPU-side register block.

---
 rtl/video_frame_monitor.sv | 145 ++++++++++++++
 tb/tb_video_frame_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/video_frame_monitor.sv
// Pixel-domain frame checker: per-frame CRC-32 over active pixels, pixel/line/hsync counts,
// draw-coordinate consistency and sticky error flags, published at each vsync assertion.
module video_frame_monitor #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned COLOR_W         = 4,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  localparam int unsigned PW             = $clog2(H_TOTAL * V_TOTAL + 1)
) (
  input  logic               pixel_clk,
  input  logic               arstn,
  input  logic               pixel_hs,
  input  logic               pixel_vs,
  input  logic               pixel_vde,
  input  logic [COLOR_W-1:0] pixel_r,
  input  logic [COLOR_W-1:0] pixel_g,
  input  logic [COLOR_W-1:0] pixel_b,
  input  logic [9:0]         drawX,
  input  logic [9:0]         drawY,
  input  logic               err_clear,
  output logic               frame_done,
  output logic [31:0]        frame_crc,
  output logic [PW-1:0]      frame_pixels,
  output logic [15:0]        frame_count,
  output logic [3:0]         err_frame,
  output logic [3:0]         err_sticky
);

  localparam int unsigned DW        = 3 * COLOR_W;
  localparam logic [31:0] CrcPoly   = 32'h04C11DB7;
  localparam logic [31:0] CrcInit   = 32'hFFFFFFFF;
  localparam logic [PW-1:0] PixExp  = PW'(H_ACTIVE * V_ACTIVE);
  localparam logic [15:0] RunExp    = 16'(H_ACTIVE);
  localparam logic [10:0] HsExp     = 11'(V_TOTAL);

  typedef enum logic {StSyncWait, StActive} state_e;

  state_e        state_q;
  logic          hs_q, vs_q, vde_q;
  logic [15:0]   run_q, line_q;
  logic [PW-1:0] pix_q;
  logic [10:0]   hs_cnt_q;
  logic [31:0]   crc_q;
  logic          len_err_q, coord_err_q;

  logic          hs_a, vs_a, boundary, hs_rise, vde_fall, run_bad, coord_bad;
  logic [15:0]   x_cur, y_cur, run_d, line_d;
  logic [PW-1:0] pix_base, pix_d;
  logic [10:0]   hs_base, hs_d;
  logic [31:0]   crc_base, crc_d;
  logic          len_err_d, coord_err_d;
  logic [3:0]    err_old;

  // Whole pixel word {r,g,b} folded in MSB first in a single cycle.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DW-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      r = (r[31] ^ d[i]) ? ((r << 1) ^ CrcPoly) : (r << 1);
    end
    return r;
  endfunction

  assign hs_a     = pixel_hs ^ SYNC_ACTIVE_LOW;
  assign vs_a     = pixel_vs ^ SYNC_ACTIVE_LOW;
  assign boundary = vs_a & ~vs_q;
  assign hs_rise  = hs_a & ~hs_q;
  assign vde_fall = ~pixel_vde & vde_q;

  // On a boundary the current cycle is the first cycle of the new frame, so every
  // accumulator restarts from its base value before this cycle's contribution.
  always_comb begin
    x_cur       = (vde_q && !boundary) ? run_q : '0;
    y_cur       = boundary ? '0 : line_q;
    run_d       = pixel_vde ? x_cur + 16'(x_cur != 16'hFFFF) : '0;
    line_d      = y_cur + 16'(vde_fall && !boundary && y_cur != 16'hFFFF);
    pix_base    = boundary ? '0 : pix_q;
    pix_d       = pix_base + PW'(pixel_vde && pix_base != '1);
    hs_base     = boundary ? '0 : hs_cnt_q;
    hs_d        = hs_base + 11'(hs_rise && hs_base != '1);
    crc_base    = boundary ? CrcInit : crc_q;
    crc_d       = pixel_vde ? crc_step(crc_base, {pixel_r, pixel_g, pixel_b}) : crc_base;
    run_bad     = vde_q && (run_q != RunExp) && (vde_fall || boundary);
    len_err_d   = !boundary && (len_err_q || run_bad);
    coord_bad   = pixel_vde && ((16'(drawX) != x_cur) || (16'(drawY) != y_cur));
    coord_err_d = (!boundary && coord_err_q) || coord_bad;
    err_old     = {hs_cnt_q != HsExp, coord_err_q, pix_q != PixExp, len_err_q || run_bad};
  end

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state_q      <= StSyncWait;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      vde_q        <= 1'b0;
      run_q        <= '0;
      line_q       <= '0;
      pix_q        <= '0;
      hs_cnt_q     <= '0;
      crc_q        <= '0;
      len_err_q    <= 1'b0;
      coord_err_q  <= 1'b0;
      frame_done   <= 1'b0;
      frame_crc    <= '0;
      frame_pixels <= '0;
      frame_count  <= '0;
      err_frame    <= '0;
      err_sticky   <= '0;
    end else begin
      hs_q       <= hs_a;
      vs_q       <= vs_a;
      vde_q      <= pixel_vde;
      frame_done <= 1'b0;
      if (err_clear) err_sticky <= '0;
      if (state_q == StActive || boundary) begin
        run_q       <= run_d;
        line_q      <= line_d;
        pix_q       <= pix_d;
        hs_cnt_q    <= hs_d;
        crc_q       <= crc_d;
        len_err_q   <= len_err_d;
        coord_err_q <= coord_err_d;
      end
      unique case (state_q)
        StSyncWait: begin
          if (boundary) state_q <= StActive;
        end
        StActive: begin
          if (boundary) begin
            frame_done   <= 1'b1;
            frame_crc    <= crc_q;
            frame_pixels <= pix_q;
            err_frame    <= err_old;
            frame_count  <= frame_count + 16'd1;
            // A coincident clear loses to the newly published flags.
            err_sticky   <= (err_clear ? 4'b0 : err_sticky) | err_old;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_monitor.sv
// Directed bench: two small-raster monitors (active-high 1-bit colour, active-low 4-bit colour)
// driven by one 10x6 raster with 8x4 active area.
module tb_video_frame_monitor;

  logic       pixel_clk = 1'b0;
  logic       arstn, hs, vs, vde, err_clear, clr_pend;
  logic [9:0] draw_x, draw_y;
  logic [2:0] val;

  logic        a_done, b_done;
  logic [31:0] a_crc, b_crc;
  logic [5:0]  a_pix, b_pix;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  a_errf, a_errs, b_errf, b_errs;

  int n_checks = 0;
  int n_err    = 0;

  always #5 pixel_clk = ~pixel_clk;

  video_frame_monitor #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_TOTAL(10), .V_TOTAL(6), .COLOR_W(1), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_a (
    .pixel_clk(pixel_clk), .arstn(arstn), .pixel_hs(hs), .pixel_vs(vs), .pixel_vde(vde),
    .pixel_r(val[2]), .pixel_g(val[1]), .pixel_b(val[0]), .drawX(draw_x), .drawY(draw_y),
    .err_clear(err_clear), .frame_done(a_done), .frame_crc(a_crc), .frame_pixels(a_pix),
    .frame_count(a_cnt), .err_frame(a_errf), .err_sticky(a_errs)
  );

  video_frame_monitor #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_TOTAL(10), .V_TOTAL(6), .COLOR_W(4), .SYNC_ACTIVE_LOW(1'b1)
  ) dut_b (
    .pixel_clk(pixel_clk), .arstn(arstn), .pixel_hs(~hs), .pixel_vs(~vs), .pixel_vde(vde),
    .pixel_r(4'hF), .pixel_g(4'h0), .pixel_b(4'h0), .drawX(draw_x), .drawY(draw_y),
    .err_clear(err_clear), .frame_done(b_done), .frame_crc(b_crc), .frame_pixels(b_pix),
    .frame_count(b_cnt), .err_frame(b_errf), .err_sticky(b_errs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic done, input int cnt, input int pix,
                         input logic [3:0] errf, input logic [3:0] errs, input logic [31:0] crc);
    chk({tag, "_a_done"}, 32'(a_done), 32'(done));
    chk({tag, "_a_count"}, 32'(a_cnt), 32'(cnt));
    chk({tag, "_a_pixels"}, 32'(a_pix), 32'(pix));
    chk({tag, "_a_err_frame"}, 32'(a_errf), 32'(errf));
    chk({tag, "_a_err_sticky"}, 32'(a_errs), 32'(errs));
    chk({tag, "_a_crc"}, a_crc, crc);
  endtask

  task automatic check_b(input string tag, input int pix, input logic [3:0] errf,
                         input logic [31:0] crc);
    chk({tag, "_b_pixels"}, 32'(b_pix), 32'(pix));
    chk({tag, "_b_err_frame"}, 32'(b_errf), 32'(errf));
    chk({tag, "_b_crc"}, b_crc, crc);
  endtask

  // Reference CRC: bit-serial, MSB first, over the 8x4 frame (one line optionally short).
  function automatic logic [31:0] crc_model(input bit wide, input int short_y);
    logic [31:0] c;
    logic [11:0] d;
    logic        fb;
    int          nb;
    c  = 32'hFFFFFFFF;
    nb = wide ? 12 : 3;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < ((y == short_y) ? 7 : 8); x++) begin
        d = wide ? 12'hF00 : 12'((x + y) & 7);
        for (int i = nb - 1; i >= 0; i--) begin
          fb = c[31] ^ d[i];
          c  = {c[30:0], 1'b0};
          if (fb) c = c ^ 32'h04C11DB7;
        end
      end
    end
    return c;
  endfunction

  task automatic cycle(input logic h, input logic v, input logic d, input int dx, input int dy,
                       input int pv);
    hs        = h;
    vs        = v;
    vde       = d;
    draw_x    = 10'(dx);
    draw_y    = 10'(dy);
    val       = 3'(pv);
    err_clear = clr_pend;
    @(posedge pixel_clk);
    #1;
    clr_pend  = 1'b0;
  endtask

  task automatic vsync_start();
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  // Rest of a frame after the boundary cycle: lines 0-1 vsync, lines 2-5 active (y = L-2).
  task automatic rest_frame(input int short_y, input int bad_y, input int nohs_y);
    int  y, dx;
    bit  act, h;
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 10; c++) begin
        if (l == 0 && c == 0) continue;
        y   = l - 2;
        act = (l >= 2) && (c < ((y == short_y) ? 7 : 8));
        h   = (c == 8) && !((l >= 2) && (y == nohs_y));
        dx  = act ? ((y == bad_y && c == 5) ? 6 : c) : 0;
        cycle(h, l < 2, act, dx, act ? y : 0, act ? ((c + y) & 7) : 0);
      end
    end
  endtask

  initial begin
    logic [31:0] crc_a_clean, crc_b_clean;
    crc_a_clean = crc_model(1'b0, -1);
    crc_b_clean = crc_model(1'b1, -1);
    clr_pend    = 1'b0;
    arstn       = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_a("reset", 1'b0, 0, 0, 4'b0, 4'b0, 32'h0);
    check_b("reset", 0, 4'b0, 32'h0);
    arstn = 1'b1;

    vsync_start();
    chk("first_boundary_done", 32'(a_done), 32'd0);
    chk("first_boundary_count", 32'(a_cnt), 32'd0);
    rest_frame(-1, -1, -1);

    vsync_start();
    check_a("clean", 1'b1, 1, 32, 4'b0000, 4'b0000, crc_a_clean);
    check_b("clean", 32, 4'b0000, crc_b_clean);
    rest_frame(1, -1, -1);
    chk("done_pulse_drop", 32'(a_done), 32'd0);
    chk("pixels_hold", 32'(a_pix), 32'd32);

    vsync_start();
    check_a("short_line", 1'b1, 2, 31, 4'b0011, 4'b0011, crc_model(1'b0, 1));
    check_b("short_line", 31, 4'b0011, crc_model(1'b1, 1));
    rest_frame(-1, -1, -1);

    vsync_start();
    check_a("clean_after_err", 1'b1, 3, 32, 4'b0000, 4'b0011, crc_a_clean);
    clr_pend = 1'b1;
    rest_frame(-1, 3, -1);
    chk("err_clear_sticky", 32'(a_errs), 32'd0);

    vsync_start();
    check_a("coord", 1'b1, 4, 32, 4'b0100, 4'b0100, crc_a_clean);
    rest_frame(-1, -1, 0);

    clr_pend = 1'b1;
    vsync_start();
    check_a("hs_count_clear_coincide", 1'b1, 5, 32, 4'b1000, 4'b1000, crc_a_clean);
    check_b("hs_count", 32, 4'b1000, crc_b_clean);

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
    arstn = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_a("mid_reset", 1'b0, 0, 0, 4'b0, 4'b0, 32'h0);
    check_b("mid_reset", 0, 4'b0, 32'h0);
    arstn = 1'b1;
    rest_frame(-1, -1, -1);
    chk("post_reset_first_done", 32'(a_done), 32'd0);
    chk("post_reset_first_count", 32'(a_cnt), 32'd0);

    vsync_start();
    check_a("post_reset_second", 1'b1, 1, 32, 4'b0000, 4'b0000, crc_a_clean);

    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    vsync_start();
    check_a("b2b_1", 1'b1, 2, 0, 4'b1010, 4'b1010, 32'hFFFFFFFF);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    vsync_start();
    check_a("b2b_2", 1'b1, 3, 0, 4'b1010, 4'b1010, 32'hFFFFFFFF);
    check_b("b2b_2", 0, 4'b1010, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
